multdiv_unit: RTL and testbench

//  Multi-cycle signed 32-bit multiply/divide unit for the execute stage. Accepts one

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/multdiv_unit_div_step.sv | 24 ++
 rtl/multdiv_unit.sv | 157 +++++++++++++++
 tb/tb_multdiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide unit
package multdiv_pkg;

  localparam int WIDTH = 32;
`ifdef MULTDIV_RADIX4_EN
  localparam int MULT_ITERS = 16;
`else
  localparam int MULT_ITERS = 32;
`endif
  localparam int DIV_ITERS = 32;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude as unsigned; INT_MIN maps to 0x80000000, which is exact as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_div_step.sv
// rtl/multdiv_unit_div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         in_bit,
  input  logic [W-1:0] divisor,
  output logic         q_bit,
  output logic [W-1:0] rem_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem < divisor always holds, so the shifted value fits in W+1 bits and
  // diff[W] is a reliable borrow.
  always_comb begin
    shifted  = {rem, in_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multi-cycle signed 32-bit Booth multiply / restoring divide
// Define MULTDIV_RADIX4_EN for radix-4 modified Booth multiply (16 iterations).
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Three guard bits keep the Booth accumulator exact for +/-2*INT_MIN.
  localparam int ACC_W = WIDTH + 3;
`ifdef MULTDIV_RADIX4_EN
  localparam int BOOTH_SHIFT = 2;
`else
  localparam int BOOTH_SHIFT = 1;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic               q_1;
  logic               neg;
  logic               dz;
  logic [WIDTH-1:0]   res_r;
  logic               exc_r;

  logic signed [ACC_W-1:0]       m_ext;
  logic signed [ACC_W-1:0]       addend;
  logic signed [ACC_W-1:0]       sum;
  logic signed [ACC_W+WIDTH:0]   booth_cat;
  logic signed [ACC_W+WIDTH:0]   booth_sh;
  logic [2*WIDTH-1:0]            prod;
  logic                          mult_exc;
  logic [WIDTH-1:0]              div_res;
  logic                          div_exc;
  logic                          dq;
  logic [WIDTH-1:0]              drem;

  always_comb begin
    m_ext  = {{3{m[WIDTH-1]}}, m};
    addend = '0;
`ifdef MULTDIV_RADIX4_EN
    case ({q[1], q[0], q_1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext <<< 1;
      3'b100:         addend = -(m_ext <<< 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
`else
    case ({q[0], q_1})
      2'b01:   addend = m_ext;
      2'b10:   addend = -m_ext;
      default: addend = '0;
    endcase
`endif
    sum       = $signed(acc) + addend;
    booth_cat = {sum, q, q_1};
    booth_sh  = booth_cat >>> BOOTH_SHIFT;
  end

  always_comb begin
    prod     = {acc[WIDTH-1:0], q};
    mult_exc = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    div_res  = neg ? -q : q;
    // A non-negative quotient with the top bit set can only be INT_MIN / -1.
    div_exc  = ~neg & q[WIDTH-1];
  end

  div_step #(.W(WIDTH)) u_div_step (
    .rem     (acc[WIDTH-1:0]),
    .in_bit  (q[WIDTH-1]),
    .divisor (m),
    .q_bit   (dq),
    .rem_next(drem)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      neg   <= 1'b0;
      dz    <= 1'b0;
      res_r <= '0;
      exc_r <= 1'b0;
    end else if (ctrl_MULT) begin
      state <= MULT;
      cnt   <= CNT_W'(MULT_ITERS);
      acc   <= '0;
      q     <= data_operandB;
      m     <= data_operandA;
      q_1   <= 1'b0;
      neg   <= 1'b0;
      dz    <= 1'b0;
    end else if (ctrl_DIV) begin
      // A zero divisor runs no iterations and completes on the next edge.
      state <= DIV;
      cnt   <= (data_operandB == '0) ? '0 : CNT_W'(DIV_ITERS);
      acc   <= '0;
      q     <= mag(data_operandA);
      m     <= mag(data_operandB);
      q_1   <= 1'b0;
      neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz    <= (data_operandB == '0);
    end else begin
      case (state)
        MULT: begin
          if (cnt != '0) begin
            acc <= booth_sh[ACC_W+WIDTH:WIDTH+1];
            q   <= booth_sh[WIDTH:1];
            q_1 <= booth_sh[0];
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_r <= prod[WIDTH-1:0];
            exc_r <= mult_exc;
            state <= DONE;
          end
        end
        DIV: begin
          if (cnt != '0) begin
            acc <= {3'b000, drem};
            q   <= {q[WIDTH-2:0], dq};
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_r <= dz ? '0 : div_res;
            exc_r <= dz | div_exc;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_result    = res_r;
  assign data_exception = exc_r;
  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
  localparam int MLAT = 17;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;
  localparam logic [31:0] IMIN = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  multdiv_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic mul, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [31:0] qq;
    if (mul) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {p[63:32] != {32{p[31]}}, p[31:0]};
    end else if (b == 32'h0) begin
      return {1'b1, 32'h0};
    end else if (a == IMIN && b == 32'hFFFF_FFFF) begin
      return {1'b1, IMIN};
    end else begin
      qq = $signed(a) / $signed(b);
      return {1'b0, qq};
    end
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", {32'h0, data_result}, {32'h0, e.res});
        check("exception", {63'h0, data_exception}, {63'h0, e.exc});
        check("rdy_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // A new start aborts whatever is pending, so the scoreboard only keeps the newest op.
  task automatic issue(input logic mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    @(negedge clock);
    sb.delete();
    e.res = er;
    e.exc = ee;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    ctrl_MULT     = mul;
    ctrl_DIV      = ~mul;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [32:0] r;
    logic        mul;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(negedge clock);
    check("rst_result", {32'h0, data_result}, 64'd0);
    check("rst_exc", {63'h0, data_exception}, 64'd0);
    check("rst_rdy", {63'h0, data_resultRDY}, 64'd0);
    check("rst_busy", {63'h0, busy}, 64'd0);
    reset_n = 1'b1;

    issue(1'b1, 32'd7, -32'sd3, 32'hFFFF_FFEB, 1'b0, MLAT);
    wait_done("mul_7x-3");
    repeat (5) @(negedge clock);
    check("hold_result", {32'h0, data_result}, {32'h0, 32'hFFFF_FFEB});
    check("hold_busy", {63'h0, busy}, 64'd0);

    issue(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, MLAT);
    wait_done("mul_ovf");
    @(negedge clock);
    check("rdy_one_cycle", {63'h0, data_resultRDY}, 64'd0);

    issue(1'b0, -32'sd20, 32'd3, 32'hFFFF_FFFA, 1'b0, DLAT);
    wait_done("div_-20/3");
    issue(1'b0, IMIN, 32'hFFFF_FFFF, IMIN, 1'b1, DLAT);
    wait_done("div_min/-1");

    issue(1'b0, 32'd5, 32'd0, 32'h0, 1'b1, 1);
    wait_done("div_by_zero");
    @(negedge clock);
    check("dz_busy_low", {63'h0, busy}, 64'd0);

    issue(1'b1, 32'd3, 32'd4, 32'd12, 1'b0, MLAT);
    repeat (9) @(negedge clock);
    issue(1'b0, 32'd100, 32'd7, 32'd14, 1'b0, DLAT);
    wait_done("abort_restart");
    repeat (40) @(negedge clock);

    issue(1'b0, 32'd1000, 32'd7, 32'd142, 1'b0, DLAT);
    repeat (10) @(negedge clock);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_result", {32'h0, data_result}, 64'd0);
    check("async_rst_exc", {63'h0, data_exception}, 64'd0);
    check("async_rst_rdy", {63'h0, data_resultRDY}, 64'd0);
    check("async_rst_busy", {63'h0, busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    issue(1'b1, 32'd2, 32'd2, 32'd4, 1'b0, MLAT);
    wait_done("mul_after_rst");

    for (int i = 0; i < 8; i++) begin
      mul = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (i == 3) b = 32'hFFFF_FFF9;
      r = model(mul, a, b);
      issue(mul, a, b, r[31:0], r[32], mul ? MLAT : ((b == 32'h0) ? 1 : DLAT));
      wait_done("random");
    end

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

endmodule
